imem_ctrl: RTL and testbench

Controller that sequences the single-port synchronous instruction RAM and shares it between two requesters: the core fetch port and the program-loader write port. A three-state mode machine (IDLE, LOAD, RUN) holds the core in stall while a program is loaded, then serves one aligned fetch per cycle. Misaligned PCs are trapped here and never reach the RAM. Sits between the fetch stage and the instruction RAM macro.

---
 rtl/imem_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// Instruction RAM sequencer: arbitrates the single-port sync RAM between the
// program loader (LOAD) and the core fetch port (RUN), trapping misaligned PCs.
module imem_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned WORD_ADDR_WIDTH = 18,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_en,
  input  logic                       ld_valid,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  input  logic [INST_WIDTH-1:0]      ld_data,
  output logic                       ld_ready,
  output logic                       ld_err,
  output logic [WORD_ADDR_WIDTH:0]   ld_words,
  input  logic                       f_req,
  input  logic [ADDR_WIDTH-1:0]      f_pc,
  output logic                       f_ready,
  output logic                       f_valid,
  output logic [INST_WIDTH-1:0]      f_inst,
  output logic                       f_misalign,
  output logic                       core_stall,
  output logic [31:0]                fetch_cnt,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0]      mem_wdata,
  input  logic [INST_WIDTH-1:0]      mem_rdata,
  output logic [1:0]                 dbg_state
);

  // Handshakes: a loader write is taken when ld_valid && ld_ready, a fetch when
  // f_req && f_ready; both ready signals depend only on state and ld_en.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [WORD_ADDR_WIDTH:0] LD_WORDS_MAX = {1'b1, {WORD_ADDR_WIDTH{1'b0}}};

  state_t state;
  state_t next_state;

  logic ld_acc;
  logic ld_aligned;
  logic ld_commit;
  logic f_acc;
  logic f_aligned;
  logic load_entry;

  assign dbg_state  = state;
  assign core_stall = (state != S_RUN);
  assign ld_ready   = (state == S_LOAD);
  assign f_ready    = (state == S_RUN) && !ld_en;

  assign ld_aligned = (ld_addr[1:0] == 2'b00);
  assign f_aligned  = (f_pc[1:0] == 2'b00);
  assign ld_acc     = ld_valid && ld_ready;
  assign f_acc      = f_req && f_ready;
  // Nothing reaches the RAM while reset is held, so a write in that cycle is lost.
  assign ld_commit  = ld_acc && ld_aligned && !rst;
  assign load_entry = (next_state == S_LOAD) && (state != S_LOAD);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = ld_en ? S_LOAD : S_RUN;
      S_LOAD:  next_state = ld_en ? S_LOAD : S_RUN;
      S_RUN:   next_state = ld_en ? S_LOAD : S_RUN;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_commit) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr[WORD_ADDR_WIDTH+1:2];
      mem_wdata = ld_data;
    end else if (f_acc && f_aligned && !rst) begin
      mem_en   = 1'b1;
      mem_addr = f_pc[WORD_ADDR_WIDTH+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_valid    <= 1'b0;
      f_misalign <= 1'b0;
      ld_err     <= 1'b0;
      ld_words   <= '0;
      fetch_cnt  <= '0;
    end else begin
      f_valid    <= f_acc;
      f_misalign <= f_acc && !f_aligned;
      ld_err     <= ld_acc && !ld_aligned;
      if (f_acc) fetch_cnt <= fetch_cnt + 32'd1;
      if (load_entry)
        ld_words <= '0;
      else if (ld_commit && ld_words != LD_WORDS_MAX)
        ld_words <= ld_words + 1'b1;
    end
  end

  always_comb begin
    f_inst = '0;
    if (f_valid) f_inst = f_misalign ? NOP_INST : mem_rdata;
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a small behavioural sync RAM attached.
module tb_imem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en, ld_valid;
  logic [31:0] ld_addr, ld_data;
  logic        ld_ready, ld_err;
  logic [18:0] ld_words;
  logic        f_req;
  logic [31:0] f_pc;
  logic        f_ready, f_valid, f_misalign, core_stall;
  logic [31:0] f_inst, fetch_cnt;
  logic        mem_en, mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [0:63] = '{default: 32'h0};

  imem_ctrl dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_err(ld_err), .ld_words(ld_words),
    .f_req(f_req), .f_pc(f_pc), .f_ready(f_ready), .f_valid(f_valid),
    .f_inst(f_inst), .f_misalign(f_misalign), .core_stall(core_stall),
    .fetch_cnt(fetch_cnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  // Advance to the next falling edge; inputs change there, checks follow #1 later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    f_req = 1'b0; f_pc = '0;
    next_cycle(); next_cycle(); #1;
    checks++;
    if (dbg_state !== 2'd0 || core_stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: state=%0d stall=%b required state=0 stall=1", dbg_state, core_stall);
    end
    checks++;
    if ({f_valid, f_misalign, ld_err, ld_ready, f_ready, mem_en, mem_we} !== 7'b0 ||
        ld_words !== 19'd0 || fetch_cnt !== 32'd0 || f_inst !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: fv=%b fm=%b le=%b lr=%b fr=%b en=%b we=%b lw=%0d fc=%0d inst=%h required all 0",
               f_valid, f_misalign, ld_err, ld_ready, f_ready, mem_en, mem_we, ld_words, fetch_cnt, f_inst);
    end
    next_cycle(); rst = 1'b0; #1;
    checks++;
    if (core_stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_stall: got %b required 1", core_stall);
    end
    next_cycle(); #1;
    checks++;
    if (core_stall !== 1'b0 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL reset_to_run: stall=%b state=%0d required stall=0 state=2", core_stall, dbg_state);
    end
  endtask

  task automatic test_load_then_run();
    logic [31:0] prog [0:2];
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
    ld_en = 1'b1; #1;
    checks++;
    if (f_ready !== 1'b0) begin
      failures++;
      $display("FAIL ld_en_drops_f_ready: got %b required 0", f_ready);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      ld_valid = 1'b1; ld_addr = 32'(i * 4); ld_data = prog[i]; #1;
      checks++;
      if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
          mem_addr !== 18'(i) || mem_wdata !== prog[i]) begin
        failures++;
        $display("FAIL load_write_%0d: lr=%b en=%b we=%b addr=%h wdata=%h required 1 1 1 %h %h",
                 i, ld_ready, mem_en, mem_we, mem_addr, mem_wdata, i, prog[i]);
      end
    end
    next_cycle(); ld_valid = 1'b0; ld_en = 1'b0; #1;
    checks++;
    if (ld_words !== 19'd3) begin
      failures++;
      $display("FAIL load_words: got %0d required 3", ld_words);
    end
    next_cycle(); #1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin f_req = 1'b1; f_pc = 32'(i * 4); end
      else       f_req = 1'b0;
      #1;
      if (i < 3) begin
        checks++;
        if (f_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 18'(i)) begin
          failures++;
          $display("FAIL fetch_req_%0d: fr=%b en=%b we=%b addr=%h required 1 1 0 %h",
                   i, f_ready, mem_en, mem_we, mem_addr, i);
        end
      end
      if (i > 0) begin
        checks++;
        if (f_valid !== 1'b1 || f_misalign !== 1'b0 || f_inst !== prog[i-1]) begin
          failures++;
          $display("FAIL fetch_resp_%0d: fv=%b fm=%b inst=%h required 1 0 %h",
                   i - 1, f_valid, f_misalign, f_inst, prog[i-1]);
        end
      end
      next_cycle();
    end
    #1;
    checks++;
    if (fetch_cnt !== 32'd3 || f_valid !== 1'b0 || f_inst !== 32'd0) begin
      failures++;
      $display("FAIL fetch_count_idle: cnt=%0d fv=%b inst=%h required 3 0 0", fetch_cnt, f_valid, f_inst);
    end
  endtask

  task automatic test_misaligned_fetch();
    f_req = 1'b1; f_pc = 32'h6; #1;
    checks++;
    if (f_ready !== 1'b1 || mem_en !== 1'b0 || mem_addr !== 18'd0) begin
      failures++;
      $display("FAIL misfetch_no_ram: fr=%b en=%b addr=%h required 1 0 0", f_ready, mem_en, mem_addr);
    end
    next_cycle(); f_req = 1'b0; #1;
    checks++;
    if (f_valid !== 1'b1 || f_misalign !== 1'b1 || f_inst !== 32'h0000_0013 || fetch_cnt !== 32'd4) begin
      failures++;
      $display("FAIL misfetch_resp: fv=%b fm=%b inst=%h cnt=%0d required 1 1 00000013 4",
               f_valid, f_misalign, f_inst, fetch_cnt);
    end
    next_cycle();
  endtask

  task automatic test_misaligned_load();
    ld_en = 1'b1;
    next_cycle(); #1;
    checks++;
    if (core_stall !== 1'b1 || ld_words !== 19'd0) begin
      failures++;
      $display("FAIL reload_entry: stall=%b words=%0d required 1 0", core_stall, ld_words);
    end
    ld_valid = 1'b1; ld_addr = 32'hC; ld_data = 32'h1111_1111;
    next_cycle(); ld_addr = 32'h2; ld_data = 32'hDEAD_BEEF; #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || ld_err !== 1'b0 || ld_words !== 19'd1) begin
      failures++;
      $display("FAIL misload_no_ram: en=%b we=%b err=%b words=%0d required 0 0 0 1",
               mem_en, mem_we, ld_err, ld_words);
    end
    next_cycle(); ld_valid = 1'b0; #1;
    checks++;
    if (ld_err !== 1'b1 || ld_words !== 19'd1) begin
      failures++;
      $display("FAIL misload_err: err=%b words=%0d required 1 1", ld_err, ld_words);
    end
    next_cycle(); ld_en = 1'b0; #1;
    checks++;
    if (ld_err !== 1'b0) begin
      failures++;
      $display("FAIL misload_err_pulse: err=%b required 0", ld_err);
    end
    next_cycle(); f_req = 1'b1; f_pc = 32'hC;
    next_cycle(); f_pc = 32'h0010_0004; #1;
    checks++;
    if (f_valid !== 1'b1 || f_inst !== 32'h1111_1111 || mem_addr !== 18'd1) begin
      failures++;
      $display("FAIL load_readback: fv=%b inst=%h addr=%h required 1 11111111 1", f_valid, f_inst, mem_addr);
    end
    next_cycle(); f_req = 1'b0; #1;
    checks++;
    if (f_valid !== 1'b1 || f_inst !== 32'h00A0_0113 || fetch_cnt !== 32'd6) begin
      failures++;
      $display("FAIL alias_fetch: fv=%b inst=%h cnt=%0d required 1 00a00113 6", f_valid, f_inst, fetch_cnt);
    end
    next_cycle();
  endtask

  task automatic test_mode_switch();
    f_req = 1'b1; f_pc = 32'h4;
    next_cycle(); ld_en = 1'b1; f_pc = 32'h8; #1;
    checks++;
    if (f_ready !== 1'b0 || mem_en !== 1'b0 || f_valid !== 1'b1 || f_inst !== 32'h00A0_0113 || core_stall !== 1'b0) begin
      failures++;
      $display("FAIL switch_same_cycle: fr=%b en=%b fv=%b inst=%h stall=%b required 0 0 1 00a00113 0",
               f_ready, mem_en, f_valid, f_inst, core_stall);
    end
    next_cycle(); f_req = 1'b0; #1;
    checks++;
    if (core_stall !== 1'b1 || f_valid !== 1'b0 || fetch_cnt !== 32'd7 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL switch_next_cycle: stall=%b fv=%b cnt=%0d state=%0d required 1 0 7 1",
               core_stall, f_valid, fetch_cnt, dbg_state);
    end
  endtask

  task automatic test_reset_mid_load();
    rst = 1'b1; ld_valid = 1'b1; ld_addr = 32'h10; ld_data = 32'h1234_5678; #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_blocks_write: we=%b required 0", mem_we);
    end
    next_cycle(); rst = 1'b0; ld_valid = 1'b0; ld_en = 1'b0; #1;
    checks++;
    if (dbg_state !== 2'd0 || ld_words !== 19'd0 || fetch_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_load: state=%0d words=%0d cnt=%0d required 0 0 0", dbg_state, ld_words, fetch_cnt);
    end
    next_cycle(); f_req = 1'b1; f_pc = 32'h10;
    next_cycle(); f_req = 1'b0; #1;
    checks++;
    if (f_valid !== 1'b1 || f_inst !== 32'h0) begin
      failures++;
      $display("FAIL rst_word_unwritten: fv=%b inst=%h required 1 00000000", f_valid, f_inst);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_then_run();
    test_misaligned_fetch();
    test_misaligned_load();
    test_mode_switch();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
